// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types, size codes and helpers for the memory-access stage
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_8000;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;
  typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10, SIZE_R = 2'b11} mem_size_e;
  typedef struct packed {
    logic [29:0] waddr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [1:0]  lane;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  dst;
    logic        wreg;
    logic [31:0] npc;
  } acc_t;
  function automatic logic misaligned(logic [1:0] size, logic [1:0] a);
    return size == SIZE_R || (size == SIZE_H && a[0]) || (size == SIZE_W && a != 2'b00);
  endfunction
  function automatic logic [3:0] byte_en(logic [1:0] size, logic [1:0] a);
    return size == SIZE_B ? 4'b0001 << a : size == SIZE_H ? 4'b0011 << a : 4'b1111;
  endfunction
  function automatic logic [31:0] store_lanes(logic [1:0] size, logic [31:0] d);
    return size == SIZE_B ? {4{d[7:0]}} : size == SIZE_H ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/memory_access_if.sv
// memory_access_if: data-memory request/response bus
interface memory_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, input dmem_rdata, dmem_ack);
  modport slave (input dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, output dmem_rdata, dmem_ack);
endinterface

// File: rtl/load_align.sv
// load_align: selects the addressed lane of a read word and sign/zero-extends it
module load_align import cpu_pkg::*; (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);
  logic [31:0] sh;
  assign sh = rdata_i >> {lane_i, 3'b000};
  assign data_o = size_i == SIZE_B ? {{24{~unsigned_i & sh[7]}}, sh[7:0]} :
                  size_i == SIZE_H ? {{16{~unsigned_i & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/memory_access.sv
// memory_access: MEM stage issuing data-memory accesses and registering writeback results
module memory_access import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [31:0]     alu_result,
  input  logic [31:0]     store_data,
  input  logic [4:0]      dst_addr_in,
  input  logic            w_reg_in,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic [31:0]     next_pc_in,
  memory_access_if.master dmem,
  output logic            stall,
  output logic            w_reg,
  output logic [31:0]     rd_data,
  output logic [4:0]      dst_addr,
  output logic [31:0]     next_pcD,
  output logic            exc_misalign,
  output logic            exc_buserr
);
  state_e      state_q, state_d;
  acc_t        acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        w_reg_q, w_reg_d, mis_q, mis_d, berr_q, berr_d;
  logic [31:0] rd_q, rd_d, npc_q, npc_d, load_data;
  logic [4:0]  dst_q, dst_d;
  logic        is_mem, bad, go;
  assign is_mem = valid_in && (mem_read || mem_write);
  assign bad = misaligned(mem_size, alu_result[1:0]);
  assign go = state_q == IDLE && is_mem && !bad;
  assign stall = go || state_q == ACCESS;
  assign dmem.dmem_req = state_q == ACCESS;
  assign dmem.dmem_we = acc_q.we;
  assign dmem.dmem_addr = {acc_q.waddr, 2'b00};
  assign dmem.dmem_wdata = acc_q.wdata;
  assign dmem.dmem_be = acc_q.be;
  assign w_reg = w_reg_q;
  assign rd_data = rd_q;
  assign dst_addr = dst_q;
  assign next_pcD = npc_q;
  assign exc_misalign = mis_q;
  assign exc_buserr = berr_q;
  load_align u_align (
    .rdata_i    (dmem.dmem_rdata),
    .lane_i     (acc_q.lane),
    .size_i     (acc_q.size),
    .unsigned_i (acc_q.uns),
    .data_o     (load_data)
  );
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    w_reg_d = 1'b0;
    rd_d = rd_q;
    dst_d = dst_q;
    npc_d = npc_q;
    mis_d = state_q == IDLE && is_mem && bad;
    berr_d = 1'b0;
    if (state_q == IDLE) begin
      if (valid_in && !(mem_read || mem_write)) begin
        w_reg_d = w_reg_in;
        rd_d = alu_result;
        dst_d = dst_addr_in;
        npc_d = next_pc_in;
      end
      if (go) begin
        state_d = ACCESS;
        cnt_d = '0;
        acc_d = '{waddr: alu_result[31:2], we: mem_write,
                  wdata: store_lanes(mem_size, store_data), be: byte_en(mem_size, alu_result[1:0]),
                  lane: alu_result[1:0], size: mem_size, uns: mem_unsigned,
                  dst: dst_addr_in, wreg: w_reg_in, npc: next_pc_in};
      end
    end else if (dmem.dmem_ack) begin
      state_d = IDLE;
      w_reg_d = acc_q.wreg && !acc_q.we;
      rd_d = acc_q.we ? rd_q : load_data;
      dst_d = acc_q.dst;
      npc_d = acc_q.npc;
    end else if (cnt_q == 8'(TIMEOUT)) begin
      state_d = IDLE;
      berr_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      w_reg_q <= 1'b0;
      rd_q <= '0;
      dst_q <= '0;
      npc_q <= RESET_PC;
      mis_q <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      w_reg_q <= w_reg_d;
      rd_q <= rd_d;
      dst_q <= dst_d;
      npc_q <= npc_d;
      mis_q <= mis_d;
      berr_q <= berr_d;
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed self-checking bench for the memory-access stage
module tb_memory_access;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, w_reg_in, mem_read, mem_write, mem_unsigned;
  logic [31:0] alu_result, store_data, next_pc_in;
  logic [4:0]  dst_addr_in;
  logic [1:0]  mem_size;
  logic        stall, w_reg, exc_misalign, exc_buserr;
  logic [31:0] rd_data, next_pcD;
  logic [4:0]  dst_addr;
  int          npass = 0, nfail = 0, ntot = 0, n;
  memory_access_if dmem ();
  memory_access #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .dst_addr_in  (dst_addr_in),
    .w_reg_in     (w_reg_in),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .next_pc_in   (next_pc_in),
    .dmem         (dmem),
    .stall        (stall),
    .w_reg        (w_reg),
    .rd_data      (rd_data),
    .dst_addr     (dst_addr),
    .next_pcD     (next_pcD),
    .exc_misalign (exc_misalign),
    .exc_buserr   (exc_buserr)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle_in;
    valid_in = 0; mem_read = 0; mem_write = 0; w_reg_in = 0;
  endtask
  task automatic present(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [4:0] dst, input logic [31:0] npc);
    valid_in = 1; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    alu_result = addr; dst_addr_in = dst; w_reg_in = 1; next_pc_in = npc;
  endtask
  task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] rdata, input int waits, input logic [31:0] exp);
    present(1, 0, sz, uns, addr, 5'd9, 32'h0000_9000);
    tick();
    repeat (waits) tick();
    dmem.dmem_ack = 1; dmem.dmem_rdata = rdata;
    tick();
    dmem.dmem_ack = 0;
    idle_in();
    chk({tag, " rd_data"}, rd_data, exp);
    chk({tag, " w_reg"}, 32'(w_reg), 32'd1);
  endtask
  initial begin
    reset = 1; dmem.dmem_ack = 0; dmem.dmem_rdata = '0;
    idle_in(); mem_size = 0; mem_unsigned = 0; alu_result = 0; store_data = 0;
    dst_addr_in = 0; next_pc_in = 0;
    tick(); tick();
    reset = 0;
    chk("rst w_reg", 32'(w_reg), 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst dst", 32'(dst_addr), 0);
    chk("rst next_pc", next_pcD, 32'h0000_8000);
    chk("rst req", 32'(dmem.dmem_req), 0);
    chk("rst stall", 32'(stall), 0);
    chk("rst exc", {30'd0, exc_misalign, exc_buserr}, 0);
    present(0, 0, 2'b00, 0, 32'h1234, 5'd5, 32'h0000_8004);
    #1 chk("add stall", 32'(stall), 0);
    tick();
    idle_in(); alu_result = 32'hDEAD;
    chk("add w_reg", 32'(w_reg), 1);
    chk("add dst", 32'(dst_addr), 5);
    chk("add rd_data", rd_data, 32'h1234);
    chk("add next_pc", next_pcD, 32'h0000_8004);
    tick();
    chk("bubble w_reg", 32'(w_reg), 0);
    chk("bubble rd_data", rd_data, 32'h1234);
    chk("bubble next_pc", next_pcD, 32'h0000_8004);
    present(1, 0, 2'b00, 0, 32'h103, 5'd7, 32'h0000_8008);
    n = 0;
    #1 n += int'(stall);
    chk("lb req idle", 32'(dmem.dmem_req), 0);
    tick();
    n += int'(stall);
    chk("lb req", 32'(dmem.dmem_req), 1);
    chk("lb be", 32'(dmem.dmem_be), 32'b1000);
    chk("lb addr", dmem.dmem_addr, 32'h100);
    chk("lb we", 32'(dmem.dmem_we), 0);
    tick();
    dmem.dmem_ack = 1; dmem.dmem_rdata = 32'h80FF_FF7F;
    #1 n += int'(stall);
    tick();
    dmem.dmem_ack = 0; idle_in();
    #1 n += int'(stall);
    chk("lb stall cycles", n, 3);
    chk("lb rd_data", rd_data, 32'hFFFF_FF80);
    chk("lb w_reg", 32'(w_reg), 1);
    chk("lb dst", 32'(dst_addr), 7);
    chk("lb req after", 32'(dmem.dmem_req), 0);
    load("lh", 32'h102, 2'b01, 0, 32'h80FF_1234, 0, 32'hFFFF_80FF);
    load("lbu", 32'h101, 2'b00, 1, 32'h0000_9C00, 1, 32'h0000_009C);
    load("lw", 32'h104, 2'b10, 0, 32'hCAFE_BABE, 0, 32'hCAFE_BABE);
    present(0, 1, 2'b01, 0, 32'h202, 5'd3, 32'h0000_8010);
    store_data = 32'h0000_ABCD;
    tick();
    chk("sh be", 32'(dmem.dmem_be), 32'b1100);
    chk("sh wdata", dmem.dmem_wdata, 32'hABCD_ABCD);
    chk("sh we", 32'(dmem.dmem_we), 1);
    chk("sh addr", dmem.dmem_addr, 32'h200);
    dmem.dmem_ack = 1;
    tick();
    dmem.dmem_ack = 0; idle_in();
    chk("sh w_reg", 32'(w_reg), 0);
    present(0, 1, 2'b00, 0, 32'h301, 5'd3, 32'h0000_8014);
    store_data = 32'h1234_565A;
    tick();
    chk("sb be", 32'(dmem.dmem_be), 32'b0010);
    chk("sb wdata", dmem.dmem_wdata, 32'h5A5A_5A5A);
    dmem.dmem_ack = 1;
    tick();
    dmem.dmem_ack = 0; idle_in();
    present(1, 0, 2'b10, 0, 32'h101, 5'd4, 32'h0000_8018);
    #1 chk("mis stall", 32'(stall), 0);
    tick();
    idle_in();
    chk("mis exc", 32'(exc_misalign), 1);
    chk("mis w_reg", 32'(w_reg), 0);
    chk("mis req", 32'(dmem.dmem_req), 0);
    tick();
    chk("mis pulse end", 32'(exc_misalign), 0);
    present(1, 0, 2'b10, 0, 32'h108, 5'd6, 32'h0000_801C);
    tick();
    n = 0;
    for (int i = 0; i < 20 && dmem.dmem_req; i++) begin
      n++;
      tick();
    end
    idle_in();
    chk("tmo req cycles", n, 5);
    chk("tmo buserr", 32'(exc_buserr), 1);
    chk("tmo w_reg", 32'(w_reg), 0);
    tick();
    chk("tmo pulse end", 32'(exc_buserr), 0);
    present(1, 0, 2'b10, 0, 32'h10C, 5'd8, 32'h0000_8020);
    tick();
    repeat (4) tick();
    dmem.dmem_ack = 1; dmem.dmem_rdata = 32'h1122_3344;
    tick();
    dmem.dmem_ack = 0; idle_in();
    chk("ack@tmo buserr", 32'(exc_buserr), 0);
    chk("ack@tmo w_reg", 32'(w_reg), 1);
    chk("ack@tmo rd_data", rd_data, 32'h1122_3344);
    chk("ack@tmo next_pc", next_pcD, 32'h0000_8020);
    dmem.dmem_ack = 1; dmem.dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem.dmem_ack = 0;
    chk("idle ack w_reg", 32'(w_reg), 0);
    chk("idle ack rd_data", rd_data, 32'h1122_3344);
    chk("idle ack req", 32'(dmem.dmem_req), 0);
    present(1, 0, 2'b10, 0, 32'h110, 5'd2, 32'h0000_8024);
    tick();
    chk("rstmid req before", 32'(dmem.dmem_req), 1);
    reset = 1;
    tick();
    idle_in();
    chk("rstmid req", 32'(dmem.dmem_req), 0);
    chk("rstmid next_pc", next_pcD, 32'h0000_8000);
    chk("rstmid w_reg", 32'(w_reg), 0);
    reset = 0;
    dmem.dmem_ack = 1; dmem.dmem_rdata = 32'h5555_5555;
    tick();
    dmem.dmem_ack = 0;
    chk("rstmid no wb", 32'(w_reg), 0);
    chk("rstmid rd_data", rd_data, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter RESET_PC, default 32'h00008000: value of next_pcD after reset.
REQ-002 Parameter TIMEOUT, default 255: maximum wait cycles for dmem_ack before bus error (range 1..255).
REQ-003 Ports (name direction width meaning):
- clk in 1: single clock, rising edge.
- reset in 1: synchronous, active-high reset.
- valid_in in 1: execute stage presents an instruction this cycle.
- alu_result in 32: effective address, or result for non-memory ops.
- store_data in 32: rs2 data for stores.
- dst_addr_in in 5: destination register.
- w_reg_in in 1: instruction writes a register.
- mem_read in 1: load.
- mem_write in 1: store.
- mem_size in 2: 00 byte, 01 half, 10 word, 11 reserved.
- mem_unsigned in 1: zero-extend loads.
- next_pc_in in 32: next PC from execute.
- dmem_req out 1: memory request.
- dmem_we out 1: write enable.
- dmem_addr out 32: word-aligned address.
- dmem_wdata out 32: lane-shifted store data.
- dmem_be out 4: byte enables.
- dmem_rdata in 32: read data, valid with dmem_ack.
- dmem_ack in 1: access complete.
- stall out 1: upstream must hold its inputs.
- w_reg out 1: to writeback stage.
- rd_data out 32: to writeback stage.
- dst_addr out 5: to writeback stage.
- next_pcD out 32: to writeback stage.
- exc_misalign out 1: one-cycle misaligned-access flag.
- exc_buserr out 1: one-cycle bus-timeout flag.

Function
REQ-004 Non-memory op (valid_in, no mem_read/mem_write): one cycle later, w_reg=w_reg_in, rd_data=alu_result, dst_addr=dst_addr_in, next_pcD=next_pc_in; stall stays 0.
REQ-005 valid_in=0: next cycle w_reg=0; rd_data and dst_addr hold; next_pcD holds.
REQ-006 States: IDLE, ACCESS. IDLE->ACCESS on an aligned valid load or store. ACCESS->IDLE on dmem_ack or on timeout.
REQ-007 In ACCESS: dmem_req=1, and dmem_addr/we/wdata/be held stable from a captured copy; stall=1 combinationally from the cycle the op is presented until the ack cycle inclusive.
REQ-008 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. dmem_wdata replicates the byte or half into every lane.
REQ-009 Misaligned access: half with addr[0]=1, word with addr[1:0]!=0, or size 11. No dmem_req; next cycle exc_misalign=1 and w_reg=0; no stall.
REQ-010 Load data is taken from the lane selected by addr[1:0], then sign- or zero-extended per mem_unsigned. It is registered into rd_data the cycle after dmem_ack, with w_reg=w_reg_in.
REQ-011 Store: on ack, w_reg=0 next cycle.
REQ-012 Latency: one cycle if dmem_ack is asserted in the first ACCESS cycle, otherwise 1+N cycles.
REQ-013 An 8-bit wait counter clears on entering ACCESS and increments per cycle without ack. At count==TIMEOUT: drop dmem_req, exc_buserr=1 next cycle, w_reg=0, return to IDLE.
REQ-014 dmem_ack in IDLE is ignored.
REQ-015 dmem_ack in the same cycle as timeout: ack wins, no bus error.

Reset
REQ-016 On clk edge with reset=1: state IDLE, counter 0, dmem_req=0, stall=0, w_reg=0, rd_data=0, dst_addr=0, next_pcD=RESET_PC, exc flags 0.
REQ-017 Reset during ACCESS abandons the access immediately; no writeback occurs for it.

Structure
REQ-018 State encoding, mem_size codes and the RESET_PC default live in shared package cpu_pkg.
REQ-019 The lane-select/extend logic is one combinational sub-module, load_align.

Verification
REQ-020 ADD result 32'h1234 to x5 -> next cycle w_reg=1, dst_addr=5, rd_data=32'h1234, stall=0.
REQ-021 LB at 32'h103 with rdata 32'h80FF_FF7F and ack after 2 cycles -> stall for 3 cycles, be=4'b1000, rd_data=32'hFFFF_FF80.
REQ-022 SH 32'hABCD to 32'h202 -> be=4'b1100, wdata=32'hABCD_ABCD, dmem_we=1, w_reg=0.
REQ-023 LW at 32'h101 -> no dmem_req, exc_misalign pulse, w_reg=0.
REQ-024 LW with no ack, TIMEOUT=4 -> req drops after 5 ACCESS cycles, exc_buserr pulse.
REQ-025 Reset asserted mid-ACCESS -> next cycle dmem_req=0, next_pcD=32'h00008000, w_reg=0.
